// File: rtl/pc.sv
// Program counter register for the RV32I fetch stage.
// Holds the current instruction address and loads the next-PC value from the
// upstream mux when enabled. Synchronous active-low reset has priority over load.
// Optional feature macro: PC_ALIGN_EN forces out[1:0] to 2'b00 on every load
// (reset value included), guaranteeing word-aligned fetch; requires WIDTH >= 2.
module pc #(
    parameter int unsigned             WIDTH       = 32,
    parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

`ifdef PC_ALIGN_EN
    // Clears the two low address bits of anything written into the register.
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [WIDTH-1:0] RESET_LOAD = RESET_VALUE & ALIGN_MASK;
`else
    localparam logic [WIDTH-1:0] RESET_LOAD = RESET_VALUE;
`endif

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] load_value;

    // Select the value written on an enabled load.
    always_comb begin
`ifdef PC_ALIGN_EN
        load_value = in & ALIGN_MASK;
`else
        load_value = in;
`endif
    end

    // PC register: reset wins over load; en low stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_LOAD;
        end else if (en) begin
            pc_q <= load_value;
        end
    end

    assign out = pc_q;

endmodule

// File: tb/tb_pc.sv
// Directed self-checking bench for the pc register (WIDTH = 32, RESET_VALUE = 0).
// Expected values are hand-computed; alignment masking applied when PC_ALIGN_EN is defined.
module tb_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] in;
    logic [31:0] out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pc #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .in  (in),
        .out (out)
    );

    // 10 time-unit clock period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] v);
`ifdef PC_ALIGN_EN
        return v & 32'hFFFF_FFFC;
`else
        return v;
`endif
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset with a pending load
        rst = 1'b0; en = 1'b1; in = 32'h0000_0040;
        tick();
        check("reset", out, 32'h0000_0000);

        // 2. Loads
        rst = 1'b1; in = 32'd4;
        tick();
        check("load_4", out, align(32'd4));
        in = 32'd15;
        tick();
        check("load_15", out, align(32'd15));

        // 3. Stall for three edges
        en = 1'b0; in = 32'd20;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall", out, align(32'd15));
        end

        // 4. Reset mid-operation, then release with a load
        en = 1'b1; in = 32'd20; rst = 1'b0;
        tick();
        check("mid_reset", out, 32'h0000_0000);
        rst = 1'b1; in = 32'd8;
        tick();
        check("release_load", out, align(32'd8));

        // Release with en low holds the reset value
        rst = 1'b0;
        tick();
        check("reset_again", out, 32'h0000_0000);
        rst = 1'b1; en = 1'b0; in = 32'd100;
        tick();
        check("release_hold", out, 32'h0000_0000);

        // en toggling during reset has no effect
        rst = 1'b1; en = 1'b1; in = 32'd36;
        tick();
        check("pre_toggle_load", out, align(32'd36));
        rst = 1'b0; en = 1'b0; in = 32'd44;
        tick();
        check("rst_en0", out, 32'h0000_0000);
        en = 1'b1;
        tick();
        check("rst_en1", out, 32'h0000_0000);
        rst = 1'b1;

        // 5. Boundary values
        in = 32'hFFFF_FFFF;
        tick();
        check("all_ones", out, align(32'hFFFF_FFFF));
        in = 32'h0000_0000;
        tick();
        check("zero", out, 32'h0000_0000);

        // 6. Input glitches between edges
        in = 32'd24;
        #2;
        check("glitch_mid_a", out, 32'h0000_0000);
        in = 32'd28;
        #2;
        check("glitch_mid_b", out, 32'h0000_0000);
        in = 32'd33;
        tick();
        check("glitch_edge", out, align(32'd33));
        in = 32'd48;
        #3;
        check("glitch_mid_c", out, align(32'd33));
        tick();
        check("glitch_edge2", out, align(32'd48));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
